// File: rtl/track_recorder.sv
// Live note stream recorder: one track byte per time unit written into a sync-read buffer,
// using the same rest/onset/tie byte format the player consumes.
module track_recorder #(
    parameter int UNIT_CYCLES = 5000000,
    parameter int DEPTH       = 1550,
    parameter int ADDR_W      = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [6:0]        key_note,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic [ADDR_W-1:0] rec_len,
    output logic              recording,
    output logic              unit_tick,
    output logic              done,
    output logic              overflow
);

    localparam int CNT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LEN_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REC,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] rec_len_q, rec_len_d;
    logic [6:0]        prev_note_q, prev_note_d;
    logic [6:0]        key_prev_q, key_prev_d;
    logic              retrig_q, retrig_d;
    logic              overflow_q, overflow_d;
    logic              unit_tick_q, unit_tick_d;
    logic              done_q, done_d;

    logic              wr_en;
    logic [7:0]        wr_byte;
    logic              key_changed;
    logic              unit_end;

    logic [7:0]        mem [0:DEPTH-1];
    logic [7:0]        rd_data_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rec_len_d   = rec_len_q;
        prev_note_d = prev_note_q;
        key_prev_d  = key_prev_q;
        retrig_d    = retrig_q;
        overflow_d  = overflow_q;
        unit_tick_d = 1'b0;
        done_d      = 1'b0;
        wr_en       = 1'b0;
        wr_byte     = 8'h00;
        key_changed = (key_note != key_prev_q);
        unit_end    = (cnt_q == CNT_LAST);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_REC;
                    cnt_d       = '0;
                    rec_len_d   = '0;
                    overflow_d  = 1'b0;
                    prev_note_d = 7'd0;
                    retrig_d    = 1'b0;
                    key_prev_d  = key_note;
                end
            end
            S_REC: begin
                key_prev_d = key_note;
                retrig_d   = retrig_q | key_changed;
                cnt_d      = cnt_q + 1'b1;
                if (unit_end) begin
                    wr_en = 1'b1;
                    // A change on this very cycle still counts as a re-articulation.
                    if (key_note == 7'd0)
                        wr_byte = 8'h00;
                    else if (key_note == prev_note_q && !retrig_q && !key_changed)
                        wr_byte = {1'b1, key_note};
                    else
                        wr_byte = {1'b0, key_note};
                    rec_len_d   = rec_len_q + 1'b1;
                    prev_note_d = key_note;
                    retrig_d    = 1'b0;
                    cnt_d       = '0;
                    unit_tick_d = 1'b1;
                    if (rec_len_q == LEN_LAST) begin
                        overflow_d = 1'b1;
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                    end
                end
                if (stop) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rec_len_q   <= '0;
            prev_note_q <= 7'd0;
            key_prev_q  <= 7'd0;
            retrig_q    <= 1'b0;
            overflow_q  <= 1'b0;
            unit_tick_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rec_len_q   <= rec_len_d;
            prev_note_q <= prev_note_d;
            key_prev_q  <= key_prev_d;
            retrig_q    <= retrig_d;
            overflow_q  <= overflow_d;
            unit_tick_q <= unit_tick_d;
            done_q      <= done_d;
        end
    end

    // Storage is deliberately not reset; the rec_len guard on reads hides stale bytes.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[rec_len_q[IDX_W-1:0]] <= wr_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data_q <= 8'h00;
        else if (rd_addr < rec_len_q)
            rd_data_q <= mem[rd_addr[IDX_W-1:0]];
        else
            rd_data_q <= 8'h00;
    end

    assign rd_data   = rd_data_q;
    assign rec_len   = rec_len_q;
    assign recording = (state_q == S_REC);
    assign unit_tick = unit_tick_q;
    assign done      = done_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_track_recorder.sv
// Bench for track_recorder with a short time unit and an 8-byte buffer: vector table,
// hand-written corner sequences and random recordings checked against a key-history model.
module tb_track_recorder;

    localparam int U      = 10;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              stop;
    logic [6:0]        key_note;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [ADDR_W-1:0] rec_len;
    logic              recording;
    logic              unit_tick;
    logic              done;
    logic              overflow;

    int errors = 0;
    int checks = 0;

    // hist[0] is the key at the start cycle, hist[1+c] the key in recording cycle c.
    logic [6:0] hist [$];
    logic [7:0] exp_mem [DEPTH];
    int         exp_len;

    track_recorder #(.UNIT_CYCLES(U), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .key_note(key_note),
        .rd_addr(rd_addr), .rd_data(rd_data), .rec_len(rec_len), .recording(recording),
        .unit_tick(unit_tick), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] k [3];
        int         alt_unit;
        int         alt_off;
        int         alt_len;
        logic [6:0] alt_key;
        logic [7:0] exp [3];
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic begin_rec(input logic [6:0] key, input logic with_stop);
        key_note = key;
        start    = 1'b1;
        stop     = with_stop;
        hist.delete();
        hist.push_back(key);
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("rec_entry_recording", recording, 1);
        check("rec_entry_len", rec_len, 0);
        check("rec_entry_overflow", overflow, 0);
    endtask

    // Byte k is a tie only if the note was held unchanged from the previous write sample
    // through this unit's sample; otherwise it is an onset (or a rest for key 0).
    task automatic build_expected();
        int  n;
        logic [6:0] key;
        logic tie;
        n = (hist.size() - 1) / U;
        if (n > DEPTH) n = DEPTH;
        exp_len = n;
        for (int k = 0; k < n; k++) begin
            key = hist[k*U + U];
            tie = (k > 0);
            for (int i = k*U; i <= k*U + U; i++)
                if (hist[i] != key) tie = 1'b0;
            if (key == 7'd0)      exp_mem[k] = 8'h00;
            else if (tie)         exp_mem[k] = {1'b1, key};
            else                  exp_mem[k] = {1'b0, key};
        end
    endtask

    task automatic readback(input string name);
        for (int a = 0; a < 2**ADDR_W; a++) begin
            rd_addr = ADDR_W'(a);
            step();
            check(name, rd_data, (a < exp_len) ? exp_mem[a] : 8'h00);
        end
    endtask

    function automatic logic [6:0] rand_key();
        case ($urandom_range(0, 3))
            0:       return 7'd0;
            1:       return 7'h47;
            2:       return 7'h3F;
            default: return 7'($urandom_range(1, 127));
        endcase
    endfunction

    vec_t vecs [8];

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        key_note = 7'd0;
        rd_addr  = '0;
        #3;
        check("reset_recording", recording, 0);
        check("reset_rec_len", rec_len, 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_unit_tick", unit_tick, 0);
        check("reset_done", done, 0);
        check("reset_overflow", overflow, 0);
        #9 rst_n = 1'b1;
        step();

        // stop while idle is ignored
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("idle_stop_ignored", recording, 0);
        check("idle_stop_no_done", done, 0);

        vecs[0] = '{k:'{7'h47,7'h47,7'h47}, alt_unit:-1, alt_off:0, alt_len:0, alt_key:7'h00, exp:'{8'h47,8'hC7,8'hC7}};
        vecs[1] = '{k:'{7'h47,7'h47,7'h47}, alt_unit:1,  alt_off:4, alt_len:2, alt_key:7'h00, exp:'{8'h47,8'h47,8'hC7}};
        vecs[2] = '{k:'{7'h00,7'h3F,7'h3F}, alt_unit:-1, alt_off:0, alt_len:0, alt_key:7'h00, exp:'{8'h00,8'h3F,8'hBF}};
        vecs[3] = '{k:'{7'h3F,7'h40,7'h40}, alt_unit:-1, alt_off:0, alt_len:0, alt_key:7'h00, exp:'{8'h3F,8'h40,8'hC0}};
        vecs[4] = '{k:'{7'h3F,7'h00,7'h3F}, alt_unit:-1, alt_off:0, alt_len:0, alt_key:7'h00, exp:'{8'h3F,8'h00,8'h3F}};
        vecs[5] = '{k:'{7'h47,7'h47,7'h47}, alt_unit:0,  alt_off:4, alt_len:2, alt_key:7'h00, exp:'{8'h47,8'hC7,8'hC7}};
        vecs[6] = '{k:'{7'h12,7'h12,7'h34}, alt_unit:-1, alt_off:0, alt_len:0, alt_key:7'h00, exp:'{8'h12,8'h92,8'h34}};
        vecs[7] = '{k:'{7'h47,7'h47,7'h47}, alt_unit:1,  alt_off:8, alt_len:1, alt_key:7'h48, exp:'{8'h47,8'h47,8'hC7}};

        foreach (vecs[v]) begin
            begin_rec(vecs[v].k[0], 1'b0);
            for (int c = 0; c < 3*U; c++) begin
                int u, off;
                u   = c / U;
                off = c % U;
                key_note = (u == vecs[v].alt_unit && off >= vecs[v].alt_off &&
                            off < vecs[v].alt_off + vecs[v].alt_len) ? vecs[v].alt_key : vecs[v].k[u];
                stop = (c == 3*U - 1);
                step();
                stop = 1'b0;
                check($sformatf("vec%0d_tick_c%0d", v, c), unit_tick, (off == U - 1) ? 1 : 0);
            end
            check($sformatf("vec%0d_done", v), done, 1);
            check($sformatf("vec%0d_recording", v), recording, 0);
            check($sformatf("vec%0d_len", v), rec_len, 3);
            step();
            check($sformatf("vec%0d_done_once", v), done, 0);
            for (int a = 0; a < 4; a++) begin
                rd_addr = ADDR_W'(a);
                step();
                check($sformatf("vec%0d_byte%0d", v, a), rd_data, (a < 3) ? vecs[v].exp[a] : 8'h00);
            end
        end

        // buffer fill: 8 held units, automatic stop, sticky overflow
        begin
            int done_cnt;
            done_cnt = 0;
            begin_rec(7'h47, 1'b0);
            for (int c = 0; c < DEPTH*U + 15; c++) begin
                step();
                if (done) done_cnt++;
            end
            check("full_len", rec_len, DEPTH);
            check("full_overflow", overflow, 1);
            check("full_done_pulses", done_cnt, 1);
            check("full_recording", recording, 0);
            exp_len = DEPTH;
            exp_mem[0] = 8'h47;
            for (int i = 1; i < DEPTH; i++) exp_mem[i] = 8'hC7;
            readback("full_byte");
            start = 1'b1;
            step();
            start = 1'b0;
            check("restart_clears_overflow", overflow, 0);
            check("restart_clears_len", rec_len, 0);
            stop = 1'b1;
            step();
            stop = 1'b0;
            check("restart_stop_done", done, 1);
        end

        // stop at cnt=5 of third unit, start ignored mid-recording, same-cycle write/read
        begin_rec(7'h47, 1'b0);
        for (int c = 0; c <= 2*U + 5; c++) begin
            start = (c == 12);
            stop  = (c == 2*U + 5);
            rd_addr = (c == U + 9 || c == U + 10) ? ADDR_W'(1) : ADDR_W'(0);
            step();
            start = 1'b0;
            stop  = 1'b0;
            if (c == U + 9)  check("read_during_write", rd_data, 8'h00);
            if (c == U + 10) check("read_after_write", rd_data, 8'hC7);
        end
        check("midstop_len", rec_len, 2);
        check("midstop_done", done, 1);
        rd_addr = ADDR_W'(2);
        step();
        check("midstop_done_once", done, 0);
        check("midstop_addr2", rd_data, 8'h00);
        rd_addr = ADDR_W'(1);
        step();
        check("midstop_addr1", rd_data, 8'hC7);

        // asynchronous reset mid-recording
        begin_rec(7'h47, 1'b0);
        for (int c = 0; c < U + 4; c++) step();
        rst_n = 1'b0;
        #2;
        check("rst_mid_recording", recording, 0);
        check("rst_mid_len", rec_len, 0);
        check("rst_mid_rd_data", rd_data, 0);
        check("rst_mid_tick", unit_tick, 0);
        #2 rst_n = 1'b1;
        exp_len = 0;
        readback("rst_mid_read");

        // random recordings against the key-history model
        for (int r = 0; r < 8; r++) begin
            int  n;
            logic full_run;
            full_run = (r == 3);
            n = full_run ? DEPTH*U : $urandom_range(1, DEPTH*U);
            begin_rec(rand_key(), 1'($urandom_range(0, 1)));
            for (int c = 0; c < n; c++) begin
                if ($urandom_range(0, 9) == 0) key_note = rand_key();
                start = ($urandom_range(0, 30) == 0);
                stop  = !full_run && (c == n - 1);
                hist.push_back(key_note);
                step();
                start = 1'b0;
                stop  = 1'b0;
            end
            build_expected();
            check($sformatf("rand%0d_done", r), done, 1);
            for (int c = 0; c < 5; c++) begin
                key_note = rand_key();
                step();
            end
            check($sformatf("rand%0d_len", r), rec_len, exp_len);
            check($sformatf("rand%0d_overflow", r), overflow, (exp_len == DEPTH) ? 1 : 0);
            check($sformatf("rand%0d_recording", r), recording, 0);
            readback($sformatf("rand%0d_byte", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
